// File: rtl/bram_port_arbiter_pkg.sv
// Shared types for the two-requester BRAM port arbiter: FSM states, owner IDs and
// the response-pipe tag.
package bram_port_arbiter_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    typedef struct packed {
        logic vld;
        logic own;
    } rsp_tag_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Request/response channels of both requesters plus the BRAM port, seen from the arbiter
// (slave) and from the clients/BRAM side (master).
interface bram_port_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  m0_valid, m0_we, m0_ready, m0_rvalid;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_wdata, m0_rdata;
    logic                  m1_valid, m1_we, m1_ready, m1_rvalid;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_wdata, m1_rdata;
    logic                  bram_we, bram_re;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_din, bram_dout;
    logic                  init_done;

    modport slave (
        input  m0_valid, m0_we, m0_addr, m0_wdata,
        input  m1_valid, m1_we, m1_addr, m1_wdata,
        input  bram_dout,
        output m0_ready, m0_rvalid, m0_rdata,
        output m1_ready, m1_rvalid, m1_rdata,
        output bram_we, bram_re, bram_addr, bram_din,
        output init_done
    );

    modport master (
        output m0_valid, m0_we, m0_addr, m0_wdata,
        output m1_valid, m1_we, m1_addr, m1_wdata,
        output bram_dout,
        input  m0_ready, m0_rvalid, m0_rdata,
        input  m1_ready, m1_rvalid, m1_rdata,
        input  bram_we, bram_re, bram_addr, bram_din,
        input  init_done
    );
endinterface

// File: rtl/bram_port_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin with a combinational grant; the priority pointer
// only moves when the grant is actually taken.
module rr_arbiter_2
    import bram_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt
);
    logic prio;  // requester favoured on the next tie

    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (prio == OWN_M0) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio <= OWN_M0;
        else if (accept)
            prio <= gnt[0] ? OWN_M1 : OWN_M0;
    end
endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one single-port BRAM between requesters m0/m1 with round-robin arbitration.
// Define BRAM_ARB_INIT_EN to zero-fill the BRAM during INIT before accepting requests.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    bram_port_arbiter_if.slave    bus
);
    arb_state_e            state, state_nxt;
    logic                  run, acc, sel, sel_we;
    logic [1:0]            req, gnt;
    logic [ADDR_WIDTH-1:0] sel_addr, init_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  init_wr;
    logic                  we_q, re_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    rsp_tag_t [RD_LATENCY:0] vld_pipe;
    rsp_tag_t              rsp;

`ifdef BRAM_ARB_INIT_EN
    // Extra MSB marks the walk as finished.
    logic [ADDR_WIDTH:0] init_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            init_cnt <= '0;
        else if (init_wr)
            init_cnt <= init_cnt + 1'b1;
    end

    assign init_wr   = (state == ST_INIT) && !init_cnt[ADDR_WIDTH];
    assign init_addr = init_cnt[ADDR_WIDTH-1:0];

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && init_cnt[ADDR_WIDTH])
            state_nxt = ST_RUN;
    end
`else
    assign init_wr   = 1'b0;
    assign init_addr = '0;

    always_comb begin
        state_nxt = state;
        if (state == ST_INIT)
            state_nxt = ST_RUN;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_INIT;
        else
            state <= state_nxt;
    end

    assign run = (state == ST_RUN);
    assign req = {bus.m1_valid, bus.m0_valid} & {2{run}};

    rr_arbiter_2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (acc),
        .gnt    (gnt)
    );

    assign acc       = |gnt;
    assign sel       = gnt[1] ? OWN_M1 : OWN_M0;
    assign sel_we    = sel ? bus.m1_we    : bus.m0_we;
    assign sel_addr  = sel ? bus.m1_addr  : bus.m0_addr;
    assign sel_wdata = sel ? bus.m1_wdata : bus.m0_wdata;

    // BRAM port is registered; addr/din hold on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else if (init_wr) begin
            we_q   <= 1'b1;
            re_q   <= 1'b0;
            addr_q <= init_addr;
            din_q  <= '0;
        end else begin
            we_q <= acc & sel_we;
            re_q <= acc & ~sel_we;
            if (acc)
                addr_q <= sel_addr;
            if (acc && sel_we)
                din_q <= sel_wdata;
        end
    end

    // Stage RD_LATENCY lines up with bram_dout for the read issued RD_LATENCY+1 edges earlier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= '{vld: acc & ~sel_we, own: sel};
            for (int i = 1; i <= RD_LATENCY; i++)
                vld_pipe[i] <= vld_pipe[i-1];
        end
    end

    assign rsp = vld_pipe[RD_LATENCY];

    assign bus.m0_ready  = gnt[0];
    assign bus.m1_ready  = gnt[1];
    assign bus.m0_rvalid = rsp.vld && (rsp.own == OWN_M0);
    assign bus.m1_rvalid = rsp.vld && (rsp.own == OWN_M1);
    assign bus.m0_rdata  = bus.m0_rvalid ? bus.bram_dout : '0;
    assign bus.m1_rdata  = bus.m1_rvalid ? bus.bram_dout : '0;
    assign bus.bram_we   = we_q;
    assign bus.bram_re   = re_q;
    assign bus.bram_addr = addr_q;
    assign bus.bram_din  = din_q;
    assign bus.init_done = run;
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter: BRAM model plus a queue-based reference of
// round-robin grants, memory contents and in-order read responses.
module tb_bram_port_arbiter;
    localparam int DW = 8, AW = 4, RD_LAT = 1, DEPTH = 1 << AW;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct { int due; logic own; logic [DW-1:0] data; } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    bram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    bram_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] junk(int i);
        return DW'(i * 37 + 92);
    endfunction

    // BRAM model: known non-zero power-up contents, RD_LAT clocks read latency
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] dq  [RD_LAT];
    logic          mem_rdy = 1'b0;
    always @(posedge clk) begin
        if (!mem_rdy) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= junk(i);
            mem_rdy <= 1'b1;
        end else if (bus.bram_we) begin
            mem[bus.bram_addr] <= bus.bram_din;
        end
        if (bus.bram_re) dq[0] <= mem[bus.bram_addr];
        for (int i = 1; i < RD_LAT; i++) dq[i] <= dq[i-1];
    end
    assign bus.bram_dout = dq[RD_LAT-1];

    int n_chk = 0, n_err = 0;
    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference state
    logic [DW-1:0] ref_mem [DEPTH];
    req_t q0[$], q1[$];
    exp_t eq[$];
    logic last_own;  // 1: m1 was granted last
    int   cyc = 0;

    function automatic req_t mk(logic we, int addr, int data);
        req_t r;
        r.we = we; r.addr = AW'(addr); r.data = DW'(data);
        return r;
    endfunction

    task automatic init_seq();
`ifdef BRAM_ARB_INIT_EN
        bus.m0_valid = 1'b1; bus.m1_valid = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            chk("init_we", 32'(bus.bram_we), 1);
            chk("init_addr", 32'(bus.bram_addr), k);
            chk("init_din", 32'(bus.bram_din), 0);
            chk("init_done_lo", 32'(bus.init_done), 0);
            chk("init_ready", 32'(bus.m0_ready | bus.m1_ready), 0);
        end
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
        @(negedge clk);
        chk("init_done", 32'(bus.init_done), 1);
        chk("run_idle_we", 32'(bus.bram_we), 0);
        last_own = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic run_traffic(bit gaps, int max_cyc);
        logic p0 = 1'b0, p1 = 1'b0, g0, g1;
        int   n = 0;
        req_t r;
        exp_t e;
        while ((q0.size() != 0 || q1.size() != 0 || eq.size() != 0) && n < max_cyc) begin
            p0 = (q0.size() != 0) && (p0 || !gaps || $urandom_range(3) != 0);
            p1 = (q1.size() != 0) && (p1 || !gaps || $urandom_range(3) != 0);
            bus.m0_valid = p0;
            bus.m0_we    = p0 ? q0[0].we   : 1'($urandom);
            bus.m0_addr  = p0 ? q0[0].addr : AW'($urandom);
            bus.m0_wdata = p0 ? q0[0].data : DW'($urandom);
            bus.m1_valid = p1;
            bus.m1_we    = p1 ? q1[0].we   : 1'($urandom);
            bus.m1_addr  = p1 ? q1[0].addr : AW'($urandom);
            bus.m1_wdata = p1 ? q1[0].data : DW'($urandom);
            @(negedge clk);
            g0 = p0 && (!p1 || last_own);
            g1 = p1 && !g0;
            chk("m0_ready", 32'(bus.m0_ready), 32'(g0));
            chk("m1_ready", 32'(bus.m1_ready), 32'(g1));
            if (eq.size() != 0 && eq[0].due == cyc) begin
                e = eq.pop_front();
                chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(!e.own));
                chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(e.own));
                chk("m0_rdata", 32'(bus.m0_rdata), e.own ? 0 : 32'(e.data));
                chk("m1_rdata", 32'(bus.m1_rdata), e.own ? 32'(e.data) : 0);
            end else begin
                chk("m0_rvalid_idle", 32'(bus.m0_rvalid), 0);
                chk("m1_rvalid_idle", 32'(bus.m1_rvalid), 0);
            end
            if (g0 || g1) begin
                r = g0 ? q0.pop_front() : q1.pop_front();
                last_own = g1;
                if (g0) p0 = 1'b0; else p1 = 1'b0;
                if (r.we) begin
                    ref_mem[r.addr] = r.data;
                end else begin
                    e.due = cyc + 1 + RD_LAT; e.own = g1; e.data = ref_mem[r.addr];
                    eq.push_back(e);
                end
            end
            cyc++; n++;
            @(posedge clk); #1;
        end
        bus.m0_valid = 1'b0; bus.m1_valid = 1'b0;
        chk("traffic_timeout", 32'(q0.size() + q1.size() + eq.size()), 0);
        q0.delete(); q1.delete(); eq.delete();
    endtask

    task automatic random_reqs(int cnt);
        for (int i = 0; i < cnt; i++) begin
            if ($urandom_range(1) != 0)
                q0.push_back(mk(1'($urandom), int'($urandom_range(DEPTH-1)), int'($urandom_range(255))));
            else
                q1.push_back(mk(1'($urandom), int'($urandom_range(DEPTH-1)), int'($urandom_range(255))));
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = junk(i);
        bus.m0_valid = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_valid = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;

        // Reset values, then release at t=10
        @(negedge clk);
        chk("rst_we", 32'(bus.bram_we), 0);
        chk("rst_re", 32'(bus.bram_re), 0);
        chk("rst_addr", 32'(bus.bram_addr), 0);
        chk("rst_din", 32'(bus.bram_din), 0);
        chk("rst_ready", 32'({bus.m0_ready, bus.m1_ready}), 0);
        chk("rst_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        chk("rst_rdata", 32'({bus.m0_rdata, bus.m1_rdata}), 0);
        chk("rst_done", 32'(bus.init_done), 0);
        rst = 1'b0;
        init_seq();

        // Read back every address
        for (int i = 0; i < DEPTH; i++) q0.push_back(mk(1'b0, i, 0));
        run_traffic(1'b0, 200);

        // Single requester: write then read the next cycle
        q0.push_back(mk(1'b1, 3, 8'hA5));
        q0.push_back(mk(1'b0, 3, 0));
        run_traffic(1'b0, 50);

        // Contention: both requesters reading preloaded words
        q0.push_back(mk(1'b1, 1, 8'h11));
        q1.push_back(mk(1'b1, 2, 8'h22));
        run_traffic(1'b0, 50);
        repeat (2) begin
            q0.push_back(mk(1'b0, 1, 0));
            q1.push_back(mk(1'b0, 2, 0));
        end
        run_traffic(1'b0, 50);

        // Streaming from m1
        for (int i = 0; i < DEPTH; i++) q1.push_back(mk(1'b1, i, i));
        for (int i = 0; i < DEPTH; i++) q1.push_back(mk(1'b0, i, 0));
        run_traffic(1'b0, 200);

        // Random mixed traffic with idle gaps, then without
        random_reqs(300);
        run_traffic(1'b1, 3000);
        random_reqs(200);
        run_traffic(1'b0, 3000);

        // Reset while a read is in flight
        bus.m0_valid = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = AW'(5);
        @(negedge clk);
        chk("mr_ready", 32'(bus.m0_ready), 1);
        @(posedge clk); #1;
        bus.m0_valid = 1'b0;
        chk("mr_re_before", 32'(bus.bram_re), 1);
        #1 rst = 1'b1;
        #1;
        chk("mr_re_async", 32'(bus.bram_re), 0);
        chk("mr_we_async", 32'(bus.bram_we), 0);
        chk("mr_done_async", 32'(bus.init_done), 0);
        repeat (4) begin
            @(negedge clk);
            chk("mr_rvalid", 32'({bus.m0_rvalid, bus.m1_rvalid}), 0);
        end
        rst = 1'b0;
        chk("mr_done_release", 32'(bus.init_done), 0);
        init_seq();

        random_reqs(100);
        run_traffic(1'b1, 2000);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
